// File: rtl/pc_call_stack.sv
// pc_call_stack: 16-bit program counter with return-address stack (in/load/inc/call/ret -> out, sp, full, empty, err)
module pc_call_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = 16'h0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in,
    input  logic                     load,
    input  logic                     inc,
    input  logic                     call,
    input  logic                     ret,
    output logic [WIDTH-1:0]         out,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     full,
    output logic                     empty,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 1;
    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] pc_next;
    logic [SW-1:0]    sp_dec;
    assign pc_next = out + WIDTH'(1);
    assign sp_dec  = sp - SW'(1);
    assign full    = sp == SW'(DEPTH);
    assign empty   = sp == '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= RESET_VAL;
            sp  <= '0;
            err <= 1'b0;
        end else if (ret) begin
            if (empty) begin
                out <= pc_next;
                err <= 1'b1;
            end else begin
                out <= stack[sp_dec[AW-1:0]];
                sp  <= sp_dec;
            end
        end else if (call) begin
            out <= in;
            if (full) begin
                err <= 1'b1;
            end else begin
                stack[sp[AW-1:0]] <= pc_next;
                sp <= sp + SW'(1);
            end
        end else if (load) begin
            out <= in;
        end else if (inc) begin
            out <= pc_next;
        end
    end
endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
- 16-bit program counter with an integrated return-address stack.
- Sits directly downstream of the 16-bit 2:1 word mux. The mux selects the jump target (A-register value or ALU result) and drives `in`; this block registers the next instruction address.
- Supports hold, increment, jump, call (jump + push return address) and return (pop).
- Output `out` drives the instruction-memory address.

Parameters:
- WIDTH, 16, address/data width in bits.
- DEPTH, 4, number of return-stack entries (power of two, >= 2).
- RESET_VAL, 16'h0000, value loaded into the PC by reset.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- in  input  WIDTH  jump/call target from the upstream Mux16.
- load  input  1  jump: PC <= in.
- inc  input  1  increment: PC <= PC + 1.
- call  input  1  call: push PC+1, PC <= in.
- ret  input  1  return: PC <= top of stack, pop.
- out  output  WIDTH  current PC (registered).
- sp  output  log2(DEPTH)+1  stack occupancy, 0..DEPTH.
- full  output  1  sp == DEPTH (combinational from sp).
- empty  output  1  sp == 0 (combinational from sp).
- err  output  1  sticky fault flag: overflow or underflow occurred.

Behaviour:
- Reset, synchronous and active-high. On a clk edge with reset=1:
  - out <= RESET_VAL, sp <= 0, err <= 0.
  - Stack contents are don't-care.
  - Reset overrides every other input in that cycle, including mid-call or mid-return.
- Reset values: out=RESET_VAL, sp=0, full=0, empty=1, err=0.
- Per-edge priority when reset=0: ret > call > load > inc > hold. Only the highest-priority asserted request acts; the rest are ignored that cycle.
- ret, with sp>0: out <= stack[sp-1], sp <= sp-1.
- ret, with sp==0 (underflow): out <= out + 1, sp unchanged, err <= 1.
- call, with sp<DEPTH: stack[sp] <= out + 1, sp <= sp+1, out <= in.
- call, with sp==DEPTH (overflow): out <= in, stack and sp unchanged, err <= 1. The return address is lost.
- load: out <= in. Stack untouched.
- inc: out <= out + 1.
- Hold (no request asserted): all state unchanged.
- Arithmetic: every +1 is modulo 2^WIDTH. 16'hFFFF + 1 = 16'h0000 with no flag. The pushed return address wraps the same way.
- Latency: one cycle. New out is visible after the edge that samples the request. No combinational path from inputs to out, sp or err.
- err stays 1 until reset.
- Stack storage uses DEPTH registers of WIDTH bits, built from the codebase's Register16 / Mux16 primitives or an equivalent behavioural form.

Test Plan:
- Reset and increment:
  - Drive reset=1 for 1 cycle, then inc=1 for 3 cycles.
  - Required: out = 0000, 0001, 0002, 0003; empty=1, sp=0, err=0.
- Jump and priority:
  - From out=0003, load=1 with in=16'h0730.
  - Required: out=0730.
  - Next cycle: load=1, inc=1, in=16'ha211.
  - Required: out=a211 (load beats inc).
- Call/return nesting:
  - From out=0010: call in=0100, then call in=0200, then ret, then ret.
  - Required: out = 0100 (sp=1), 0200 (sp=2), 0101 (sp=1), 0011 (sp=0, empty=1).
- Overflow and underflow:
  - From reset, apply DEPTH+1 calls with in=0x0050.
  - Required: sp=4, full=1 after the 4th call; on the 5th, out=0050, sp stays 4, err=1.
  - Separately, after reset, assert ret with sp=0.
  - Required: out=0001, err=1, sp=0.
- Wrap-around:
  - load in=FFFF, then call in=0000, then ret.
  - Required: out=0000 after the call, pushed value 0000; after ret, out=0000.
  - Separately, inc from FFFF gives 0000.
- Reset mid-operation:
  - With sp=2 and err=1, assert reset and call together on one edge.
  - Required: out=RESET_VAL, sp=0, err=0, no push.
